// File: rtl/shift_pkg.sv
// shift_pkg: shifter op codes, operand-2 forms and fetch FSM states.
package shift_pkg;
    localparam logic [2:0] SHIFT_LSL = 3'b000;
    localparam logic [2:0] SHIFT_LSR = 3'b001;
    localparam logic [2:0] SHIFT_ASR = 3'b010;
    localparam logic [2:0] SHIFT_ROR = 3'b011;
    localparam logic [2:0] SHIFT_RRX = 3'b100;
    typedef enum logic [1:0] {F_IMM, F_ISH, F_RSH, F_ILL} form_t;
    typedef enum logic [1:0] {S_IDLE, S_RD_RM, S_RD_RS, S_HOLD} state_t;
endpackage

// File: rtl/operand2_decode.sv
// operand2_decode: splits an ARM data-processing operand 2 into form, registers,
// shift op and amount, folding the shift-by-#0 special encodings.
module operand2_decode
    import shift_pkg::*;
(
    input  logic [31:0] arm_i,
    output form_t       form_o,
    output logic [3:0]  rm_o,
    output logic [3:0]  rs_o,
    output logic [2:0]  op_o,
    output logic [7:0]  num_o,
    output logic [7:0]  imm8_o
);
    logic [1:0] sh_type;
    logic [4:0] shamt;
    logic [3:0] rot4;
    logic       unused_bits;

    assign sh_type     = arm_i[6:5];
    assign shamt       = arm_i[11:7];
    assign rot4        = arm_i[11:8];
    assign rm_o        = arm_i[3:0];
    assign rs_o        = arm_i[11:8];
    assign imm8_o      = arm_i[7:0];
    assign unused_bits = ^{arm_i[31:26], arm_i[24:12]};
    assign form_o = arm_i[25] ? F_IMM : !arm_i[4] ? F_ISH : !arm_i[7] ? F_RSH : F_ILL;
    // Immediate-shift #0: LSL stays 0, LSR/ASR mean 32, ROR means RRX by 1.
    assign op_o = form_o == F_IMM ? SHIFT_ROR :
                  form_o == F_ILL ? SHIFT_LSL :
                  (form_o == F_ISH && shamt == 5'd0 && sh_type == 2'b11) ? SHIFT_RRX :
                  {1'b0, sh_type};
    assign num_o = form_o == F_IMM ? {3'b000, rot4, 1'b0} :
                   form_o != F_ISH ? 8'd0 :
                   shamt != 5'd0   ? {3'b000, shamt} :
                   sh_type == 2'b00 ? 8'd0 :
                   sh_type == 2'b11 ? 8'd1 : 8'd32;
endmodule

// File: rtl/shift_operand_fetch.sv
// shift_operand_fetch: fetches Rm/Rs for the barrel shifter over a single
// register-file read port and holds SHIFT_OP/Shift_Data/Shift_Num under valid/ready.
module shift_operand_fetch
    import shift_pkg::*;
#(
    parameter logic [3:0] PC_R = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [32:1] instr,
    input  logic [31:0] pc_plus8,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  SHIFT_OP,
    output logic [31:0] Shift_Data,
    output logic [7:0]  Shift_Num,
    output logic        carry_passthru,
    output logic        illegal
);
    state_t      state_q, state_d;
    logic [31:0] instr_q, pc_q, data_q, dec_src;
    logic [7:0]  num_q, d_num, d_imm8;
    logic [2:0]  op_q, d_op;
    logic [3:0]  rf_addr_q, d_rm, d_rs;
    logic        illegal_q, accept, in_rd;
    form_t       d_form;

    // While fetching, decode the latched instruction; otherwise the offered one.
    operand2_decode u_dec (
        .arm_i (dec_src),
        .form_o(d_form),
        .rm_o  (d_rm),
        .rs_o  (d_rs),
        .op_o  (d_op),
        .num_o (d_num),
        .imm8_o(d_imm8)
    );

    always_comb begin
        in_rd       = state_q == S_RD_RM || state_q == S_RD_RS;
        dec_src     = in_rd ? instr_q : instr;
        instr_ready = !flush && (state_q == S_IDLE || (state_q == S_HOLD && out_ready));
        accept      = instr_ready && instr_valid;
        rf_addr     = state_q == S_RD_RM ? d_rm : state_q == S_RD_RS ? d_rs : rf_addr_q;
        state_d     = flush ? S_IDLE :
                      accept ? ((d_form == F_ISH || d_form == F_RSH) ? S_RD_RM : S_HOLD) :
                      state_q == S_RD_RM ? (d_form == F_RSH ? S_RD_RS : S_HOLD) :
                      state_q == S_RD_RS ? S_HOLD :
                      (state_q == S_HOLD && out_ready) ? S_IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            num_q     <= '0;
            op_q      <= SHIFT_LSL;
            illegal_q <= 1'b0;
            rf_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rf_addr_q <= rf_addr;
            if (accept) begin
                instr_q   <= instr;
                pc_q      <= pc_plus8;
                op_q      <= d_op;
                num_q     <= d_num;
                data_q    <= d_form == F_IMM ? {24'd0, d_imm8} : 32'd0;
                illegal_q <= d_form == F_ILL;
            end else if (!flush && state_q == S_RD_RM) begin
                // PC reads as PC+8, or PC+12 when a register shift delays the read.
                data_q <= d_rm != PC_R ? rf_rdata : d_form == F_RSH ? pc_q + 32'd4 : pc_q;
            end else if (!flush && state_q == S_RD_RS) begin
                num_q <= d_rs == PC_R ? pc_q[7:0] : rf_rdata[7:0];
            end
        end
    end

    assign out_valid      = state_q == S_HOLD;
    assign SHIFT_OP       = op_q;
    assign Shift_Data     = data_q;
    assign Shift_Num      = num_q;
    assign illegal        = illegal_q;
    assign carry_passthru = out_valid && num_q == 8'd0 && op_q != SHIFT_RRX;
endmodule

// File: tb/tb_shift_operand_fetch.sv
// tb_shift_operand_fetch: directed stimulus with a scoreboard of expected shifter
// operands, popped and compared on each out_valid/out_ready handshake.
module tb_shift_operand_fetch;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic [7:0]  num;
        logic        cp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, instr_valid = 1'b0, out_ready = 1'b0;
    logic [32:1] instr = '0;
    logic [31:0] pc_plus8 = '0, rf_rdata, Shift_Data;
    logic [3:0]  rf_addr;
    logic        instr_ready, out_valid, carry_passthru, illegal;
    logic [2:0]  SHIFT_OP;
    logic [7:0]  Shift_Num;
    logic [31:0] rf [16];
    exp_t        sb[$];
    int          total = 0, bad = 0;

    shift_operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .pc_plus8(pc_plus8),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .SHIFT_OP(SHIFT_OP), .Shift_Data(Shift_Data),
        .Shift_Num(Shift_Num), .carry_passthru(carry_passthru), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign rf_rdata = rf[rf_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [31:0] d, input logic [7:0] n,
                                input logic cp, input logic il);
        return {op, d, n, cp, il};
    endfunction

    function automatic logic [31:0] ish(input logic [3:0] rm, input logic [1:0] ty, input logic [4:0] sh);
        return 32'hE1A00000 | {20'd0, sh, ty, 1'b0, rm};
    endfunction

    function automatic logic [31:0] rsh(input logic [3:0] rm, input logic [1:0] ty, input logic [3:0] rs);
        return 32'hE1A00010 | {20'd0, rs, 1'b0, ty, 1'b0, rm};
    endfunction

    function automatic logic [31:0] imm(input logic [3:0] rot, input logic [7:0] i8);
        return 32'hE3A00000 | {20'd0, rot, i8};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("op", SHIFT_OP, e.op);
                chk("data", Shift_Data, e.data);
                chk("num", Shift_Num, e.num);
                chk("carry_passthru", carry_passthru, e.cp);
                chk("illegal", illegal, e.ill);
            end
        end
    end

    task automatic run(input logic [31:0] ins, input logic [31:0] pc, input int lat,
                       input logic [7:0] ea, input exp_t e);
        int n;
        logic [7:0] addrs;
        n = 1;
        addrs = 8'h00;
        sb.push_back(e);
        instr = ins;
        pc_plus8 = pc;
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        while (!out_valid && n < 10) begin
            addrs = {addrs[3:0], rf_addr};
            cyc();
            n++;
        end
        chk("latency", n, lat);
        if (lat > 1) chk("rf_addr_seq", addrs, ea);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + i;
        rf[1] = 32'h1; rf[2] = 32'h104; rf[3] = 32'h8000_0001;
        rf[4] = 32'hDEAD_BEEF; rf[8] = 32'h100;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_carry", carry_passthru, 0);
        chk("rst_op", SHIFT_OP, 0);
        chk("rst_data", Shift_Data, 0);
        chk("rst_num", Shift_Num, 0);
        chk("rst_rf_addr", rf_addr, 0);
        cyc();
        rst_n = 1'b1;
        #1 chk("idle_ready", instr_ready, 1);
        cyc();

        run(32'hE3A004FF, 32'h0, 1, 8'h00, mk(3'd3, 32'hFF, 8'd8, 1'b0, 1'b0));
        run(imm(4'd0, 8'h12), 32'h0, 1, 8'h00, mk(3'd3, 32'h12, 8'd0, 1'b1, 1'b0));
        run(imm(4'd15, 8'h01), 32'h0, 1, 8'h00, mk(3'd3, 32'h01, 8'd30, 1'b0, 1'b0));
        run(ish(4'd3, 2'd1, 5'd0), 32'h0, 2, 8'h03, mk(3'd1, 32'h8000_0001, 8'd32, 1'b0, 1'b0));
        run(ish(4'd4, 2'd0, 5'd0), 32'h0, 2, 8'h04, mk(3'd0, 32'hDEAD_BEEF, 8'd0, 1'b1, 1'b0));
        run(ish(4'd5, 2'd2, 5'd0), 32'h0, 2, 8'h05, mk(3'd2, 32'h1000_0005, 8'd32, 1'b0, 1'b0));
        run(ish(4'd6, 2'd3, 5'd0), 32'h0, 2, 8'h06, mk(3'd4, 32'h1000_0006, 8'd1, 1'b0, 1'b0));
        run(ish(4'd7, 2'd0, 5'd5), 32'h0, 2, 8'h07, mk(3'd0, 32'h1000_0007, 8'd5, 1'b0, 1'b0));
        run(rsh(4'd1, 2'd0, 4'd2), 32'h0, 3, 8'h12, mk(3'd0, 32'h1, 8'h04, 1'b0, 1'b0));
        run(rsh(4'd1, 2'd3, 4'd8), 32'h0, 3, 8'h18, mk(3'd3, 32'h1, 8'h00, 1'b1, 1'b0));
        run(ish(4'd15, 2'd0, 5'd2), 32'h1008, 2, 8'h0F, mk(3'd0, 32'h1008, 8'd2, 1'b0, 1'b0));
        run(rsh(4'd15, 2'd1, 4'd2), 32'h1008, 3, 8'hF2, mk(3'd1, 32'h100C, 8'h04, 1'b0, 1'b0));
        run(rsh(4'd1, 2'd2, 4'd15), 32'h1008, 3, 8'h1F, mk(3'd2, 32'h1, 8'h08, 1'b0, 1'b0));
        run(rsh(4'd15, 2'd0, 4'd8), 32'hFFFF_FFFE, 3, 8'hF8, mk(3'd0, 32'h2, 8'h00, 1'b1, 1'b0));
        run(32'hE1A00090, 32'h0, 1, 8'h00, mk(3'd0, 32'h0, 8'd0, 1'b1, 1'b1));

        // backpressure then back-to-back acceptance
        sb.push_back(mk(3'd3, 32'h3F, 8'd24, 1'b0, 1'b0));
        instr = imm(4'd12, 8'h3F);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", Shift_Data, 32'h3F);
            chk("bp_num", Shift_Num, 8'd24);
            chk("bp_ready", instr_ready, 0);
            cyc();
        end
        sb.push_back(mk(3'd3, 32'h01, 8'd0, 1'b1, 1'b0));
        instr = imm(4'd0, 8'h01);
        instr_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk("b2b_ready", instr_ready, 1);
        cyc();
        instr_valid = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", Shift_Data, 32'h01);
        cyc();
        out_ready = 1'b0;
        chk("b2b_idle", out_valid, 0);

        // flush while reading Rs
        instr = rsh(4'd1, 2'd0, 4'd2);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("fl_rd_rm", rf_addr, 1);
        cyc();
        chk("fl_rd_rs", rf_addr, 2);
        flush = 1'b1;
        #1 chk("fl_ready", instr_ready, 0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_valid", out_valid, 0);
        chk("fl_idle_ready", instr_ready, 1);
        cyc();
        chk("fl_valid_later", out_valid, 0);

        // flush beats a handshake in HOLD
        instr = imm(4'd1, 8'h77);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("flh_hold", out_valid, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        #1 chk("flh_ready", instr_ready, 0);
        cyc();
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flh_valid", out_valid, 0);

        // async reset in the middle of an Rm read
        instr = ish(4'd9, 2'd1, 5'd3);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("ar_rd_rm", rf_addr, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_rf_addr", rf_addr, 0);
        chk("ar_data", Shift_Data, 0);
        chk("ar_num", Shift_Num, 0);
        chk("ar_op", SHIFT_OP, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("ar_after_valid", out_valid, 0);
        run(ish(4'd4, 2'd0, 5'd1), 32'h0, 2, 8'h04, mk(3'd0, 32'hDEAD_BEEF, 8'd1, 1'b0, 1'b0));

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
